// File: rtl/imem_loader_if.sv
// Handshake and memory-write bundle between a byte source/host and the instruction-memory loader.
// The master side drives the load request and byte stream; the slave side is the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-2:0] len;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Loads big-endian 32-bit instruction words from a byte stream into instruction memory,
// holding the CPU until the whole program has been written.
module imem_loader #(
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  // Word count capacity expressed at len width so a full-memory load is representable.
  localparam logic [ADDR_W-2:0] DEPTH_W = {1'b1, {(ADDR_W-2){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-3:0] word_idx_q, word_idx_d;
  logic [31:0]       sr_q, sr_d;
  logic [ADDR_W-2:0] len_q, len_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              accept;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_idx_d  = word_idx_q;
    sr_d        = sr_q;
    len_d       = len_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    accept      = (state_q == S_RECV) && bus.in_valid && in_ready_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          len_d = bus.len;
          err_d = 1'b0;
          if (bus.len == '0) begin
            state_d = S_DONE;
          end else if (bus.len > DEPTH_W) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d    = S_RECV;
            byte_cnt_d = '0;
            word_idx_d = '0;
          end
        end
      end
      S_RECV: begin
        if (accept) begin
          sr_d       = {sr_q[23:0], bus.in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // The write word is taken straight from the incoming byte so WRITE can follow immediately.
          if (byte_cnt_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_addr_d  = {word_idx_q, 2'b00};
            mem_wdata_d = {sr_q[23:0], bus.in_data};
          end
        end
      end
      S_WRITE: begin
        if ({1'b0, word_idx_q} == len_q - (ADDR_W-1)'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_RECV;
          word_idx_d = word_idx_q + (ADDR_W-2)'(1);
          byte_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of the decode of the state being entered.
    in_ready_d = (state_d == S_RECV);
    mem_we_d   = (state_d == S_WRITE);
    cpu_hold_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      sr_q        <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      sr_q        <= sr_d;
      len_q       <= len_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single word, full memory with stalls, overflow,
// zero length, reset mid-load and restart from DONE.
module tb_imem_loader;

  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]        bytes [0:31];
  logic [ADDR_W-1:0] wa_q [$];
  logic [31:0]       wd_q [$];
  logic              hold_first;
  logic              done_first;

  // Record every memory write the way the instruction memory would capture it.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
  endtask

  // Caller raises start/len; this keeps the byte source running until done or a limit.
  task automatic feed(input int nbytes, input bit stalls, input bit inject,
                      input bit stop_early, input int budget, output int cycles);
    int idx;
    bit acc;
    idx = 0;
    cycles = 0;
    while (cycles < budget) begin
      if (idx < nbytes) begin
        bus.in_valid = stalls ? !((cycles % 5 == 2) || (cycles % 7 == 3)) : 1'b1;
        bus.in_data  = bytes[idx];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hEE;
      end
      acc = bus.in_valid && bus.in_ready;
      step();
      cycles++;
      if (acc) idx++;
      if (cycles == 1) begin
        hold_first = bus.cpu_hold;
        done_first = bus.done;
      end
      bus.start = inject ? (cycles % 2 == 1) : 1'b0;
      if (inject) bus.len = 4'd0;
      if (bus.done === 1'b1) break;
      if (stop_early && idx == nbytes) break;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    step(); step();
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.mem_addr !== 5'd0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    n_cmp++; if (bus.mem_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    n_cmp++; if (bus.cpu_hold !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_hold: got %b want 1", bus.cpu_hold); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    reset = 1'b0;
    step();
    n_cmp++; if (bus.cpu_hold !== 1'b1) begin n_bad++; $display("FAIL idle_cpu_hold: got %b want 1", bus.cpu_hold); end
  endtask

  task automatic test_single_word();
    int cyc;
    bytes[0] = 8'h20; bytes[1] = 8'h08; bytes[2] = 8'h00; bytes[3] = 8'h05;
    clear_writes();
    bus.start = 1'b1; bus.len = 4'd1;
    feed(4, 1'b0, 1'b0, 1'b0, 40, cyc);
    n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL single_latency: got %0d cycles want 6", cyc); end
    n_cmp++; if (wa_q.size() !== 1) begin n_bad++; $display("FAIL single_nwrites: got %0d want 1", wa_q.size()); end
    if (wa_q.size() > 0) begin
      n_cmp++; if (wa_q[0] !== 5'd0) begin n_bad++; $display("FAIL single_addr: got %h want 00", wa_q[0]); end
      n_cmp++; if (wd_q[0] !== 32'h20080005) begin n_bad++; $display("FAIL single_data: got %h want 20080005", wd_q[0]); end
    end
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b want 1", bus.done); end
    n_cmp++; if (bus.cpu_hold !== 1'b0) begin n_bad++; $display("FAIL single_cpu_hold: got %b want 0", bus.cpu_hold); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", bus.err); end
  endtask

  task automatic test_full_stalls();
    int cyc;
    logic [31:0] exp;
    for (int i = 0; i < 32; i++) bytes[i] = 8'(i * 37 + 11);
    clear_writes();
    bus.start = 1'b1; bus.len = 4'd8;
    feed(32, 1'b1, 1'b0, 1'b0, 400, cyc);
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL full_done: got %b want 1 after %0d cycles", bus.done, cyc); end
    n_cmp++; if (cyc <= 41) begin n_bad++; $display("FAIL full_stall_cycles: got %0d want more than 41", cyc); end
    n_cmp++; if (wa_q.size() !== 8) begin n_bad++; $display("FAIL full_nwrites: got %0d want 8", wa_q.size()); end
    for (int k = 0; k < 8 && k < wa_q.size(); k++) begin
      exp = {bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]};
      n_cmp++; if (wa_q[k] !== 5'(4*k)) begin n_bad++; $display("FAIL full_addr%0d: got %h want %h", k, wa_q[k], 5'(4*k)); end
      n_cmp++; if (wd_q[k] !== exp) begin n_bad++; $display("FAIL full_data%0d: got %h want %h", k, wd_q[k], exp); end
    end
  endtask

  task automatic test_overflow();
    int rdy;
    reset = 1'b1; step(); reset = 1'b0; step();
    clear_writes();
    rdy = 0;
    bus.start = 1'b1; bus.len = 4'd9; bus.in_valid = 1'b1;
    step();
    bus.start = 1'b0;
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b want 1", bus.err); end
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL ovf_done: got %b want 1", bus.done); end
    for (int i = 0; i < 6; i++) begin
      if (bus.in_ready !== 1'b0) rdy++;
      step();
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (rdy !== 0) begin n_bad++; $display("FAIL ovf_in_ready: got %0d ready cycles want 0", rdy); end
    n_cmp++; if (wa_q.size() !== 0) begin n_bad++; $display("FAIL ovf_writes: got %0d want 0", wa_q.size()); end
  endtask

  task automatic test_zero_len();
    clear_writes();
    bus.start = 1'b1; bus.len = 4'd0;
    step();
    bus.start = 1'b0;
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", bus.done); end
    n_cmp++; if (bus.cpu_hold !== 1'b0) begin n_bad++; $display("FAIL zero_cpu_hold: got %b want 0", bus.cpu_hold); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL zero_err_cleared: got %b want 0", bus.err); end
    step(); step();
    n_cmp++; if (wa_q.size() !== 0) begin n_bad++; $display("FAIL zero_writes: got %0d want 0", wa_q.size()); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    for (int i = 0; i < 8; i++) bytes[i] = 8'hA0 + 8'(i);
    reset = 1'b1; step(); reset = 1'b0; step();
    clear_writes();
    bus.start = 1'b1; bus.len = 4'd2;
    feed(6, 1'b0, 1'b0, 1'b1, 40, cyc);
    reset = 1'b1;
    step();
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL mid_mem_we: got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.mem_wdata !== 32'd0) begin n_bad++; $display("FAIL mid_mem_wdata: got %h want 0", bus.mem_wdata); end
    n_cmp++; if (bus.cpu_hold !== 1'b1) begin n_bad++; $display("FAIL mid_cpu_hold: got %b want 1", bus.cpu_hold); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b want 0", bus.done); end
    reset = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) step();
    bus.in_valid = 1'b0;
    n_cmp++; if (wa_q.size() !== 1) begin n_bad++; $display("FAIL mid_nwrites: got %0d want 1", wa_q.size()); end
    if (wa_q.size() > 0) begin
      n_cmp++; if (wd_q[0] !== 32'hA0A1A2A3) begin n_bad++; $display("FAIL mid_word0: got %h want a0a1a2a3", wd_q[0]); end
    end
  endtask

  task automatic test_restart();
    int cyc;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    bus.start = 1'b1; bus.len = 4'd1;
    feed(4, 1'b0, 1'b0, 1'b0, 40, cyc);
    n_cmp++; if (bus.cpu_hold !== 1'b0) begin n_bad++; $display("FAIL rs_pre_hold: got %b want 0", bus.cpu_hold); end
    bytes[0] = 8'hDE; bytes[1] = 8'hAD; bytes[2] = 8'hBE; bytes[3] = 8'hEF;
    clear_writes();
    bus.start = 1'b1; bus.len = 4'd1;
    feed(4, 1'b0, 1'b1, 1'b0, 40, cyc);
    n_cmp++; if (hold_first !== 1'b1) begin n_bad++; $display("FAIL rs_hold_rise: got %b want 1", hold_first); end
    n_cmp++; if (done_first !== 1'b0) begin n_bad++; $display("FAIL rs_done_drop: got %b want 0", done_first); end
    n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL rs_latency: got %0d cycles want 6", cyc); end
    n_cmp++; if (wa_q.size() !== 1) begin n_bad++; $display("FAIL rs_nwrites: got %0d want 1", wa_q.size()); end
    if (wa_q.size() > 0) begin
      n_cmp++; if (wa_q[0] !== 5'd0) begin n_bad++; $display("FAIL rs_addr: got %h want 00", wa_q[0]); end
      n_cmp++; if (wd_q[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rs_data: got %h want deadbeef", wd_q[0]); end
    end
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL rs_done: got %b want 1", bus.done); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_stalls();
    test_overflow();
    test_zero_len();
    test_reset_mid();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory the single-cycle datapath reads. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues one write per word to consecutive word-aligned byte addresses starting at 0. It holds the CPU (`cpu_hold`) from reset until a load completes, so the PC starts fetching only after the program is in place.

## Interface
Parameters:
- `ADDR_W`, default 5: byte-address width. It matches the datapath PC width (5 bits). Depth is `DEPTH = 2**(ADDR_W-2)` words.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a load. Sampled only in IDLE and DONE.
- `len` in ADDR_W-1: number of words to load, 0..2**(ADDR_W-1)-1. Sampled with `start`.
- `in_valid` in 1: byte source has data.
- `in_data` in 8: byte from the source.
- `in_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: instruction-memory write strobe, one cycle per word.
- `mem_addr` out ADDR_W: byte address of the word being written. Low 2 bits are always 0.
- `mem_wdata` out 32: assembled instruction word.
- `cpu_hold` out 1: CPU must not advance its PC while this is 1.
- `done` out 1: load finished; high for as long as the block is in DONE.
- `err` out 1: requested `len` exceeds DEPTH; cleared by the next `start` or by `reset`.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- Reset values: state IDLE, `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_hold` 1, `done` 0, `err` 0. Internal counters `byte_cnt`=0, `word_idx`=0, shift register=0.

State transitions:
- IDLE: `in_ready` 0, `cpu_hold` 1. On `start`, latch `len`:
  - `len`==0 -> DONE with no writes.
  - `len`>DEPTH -> DONE with `err`=1 and no writes.
  - Otherwise -> RECV, with `byte_cnt`=0, `word_idx`=0, `err`=0.
- RECV: `in_ready` 1. A byte is accepted when `in_valid && in_ready` at a rising edge.
  - Shift register updates as `sr <= {sr[23:0], in_data}`, so the first byte lands in bits [31:24].
  - `byte_cnt` increments. On the 4th accepted byte -> WRITE.
  - `in_valid` low stalls indefinitely with no state change.
- WRITE: exactly one cycle. `in_ready` 0, `mem_we` 1, `mem_addr` = `word_idx`<<2, `mem_wdata` = the 4 assembled bytes.
  - If `word_idx`==`len`-1 -> DONE.
  - Otherwise `word_idx`+1 and `byte_cnt`=0 -> RECV.
- DONE: `cpu_hold` 0, `done` 1, `in_ready` 0, `mem_we` 0.
  - `start` restarts a load with the same IDLE sampling rules. `cpu_hold` returns to 1 the cycle after `start`.

Boundary conditions:
- `start` while in RECV or WRITE is ignored.
- Bytes presented while `in_ready`=0 are not consumed.
- `reset` mid-load returns to IDLE: the partial word is discarded, no write is issued, and `cpu_hold`=1.
- `len`==DEPTH fills the whole memory; the last address is (DEPTH-1)<<2, with no wrap-around.
- Arithmetic: `word_idx` is ADDR_W-2 bits. `len` is compared at ADDR_W-1 bits so that DEPTH is representable.

## Timing
- All outputs are registered and decoded from the current state.
- Byte acceptance is zero-wait: `in_ready` is high for the entire RECV state.
- Word latency:
  - 4th byte accepted at edge N -> `mem_we`=1 during cycle N..N+1.
  - Memory captures the word at edge N+1.
  - RECV resumes at N+1.
- Minimum throughput: 5 cycles per word (4 byte cycles + 1 write cycle).
- Last write captured at edge M -> `done`=1 and `cpu_hold`=0 from edge M onward.
- `start` at edge S in IDLE or DONE -> `in_ready`=1 from edge S+1 when the load is valid. `err` is visible from edge S+1 when it is set.

## Test plan
- Single word:
  - Stimulus: `len`=1; bytes 0x20,0x08,0x00,0x05 with `in_valid` held high.
  - Response: one `mem_we` pulse, `mem_addr`=0, `mem_wdata`=0x20080005.
  - Then `done`=1 and `cpu_hold`=0 the next cycle, with exactly 6 cycles from `start` to `done`.
- Full memory with stalls:
  - Stimulus: `ADDR_W`=5, `len`=8, 32 bytes with random `in_valid` gaps.
  - Response: 8 writes at addresses 0,4,...,28 with correct big-endian words, and no write during a stall.
- Overflow:
  - Stimulus: `len`=9 with `ADDR_W`=5.
  - Response: `err`=1 and `done`=1 at S+1, no `mem_we`, `in_ready` never 1.
- Zero length:
  - Stimulus: `len`=0.
  - Response: `done`=1 and `cpu_hold`=0 at S+1, no writes, `err`=0.
- Reset mid-load:
  - Stimulus: `len`=2; assert `reset` after 6 bytes.
  - Response: only word 0 written. At the next edge all outputs are at reset values; the 2 pending bytes are never written.
- Restart from DONE:
  - Stimulus: after a completed load, `start` with `len`=1 while `start` pulses are also injected during RECV.
  - Response: `cpu_hold` rises the cycle after the first `start`, the RECV-phase `start` pulses are ignored, and a single write goes to address 0.
